// File: rtl/err_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : err_pkg
//  Description : Shared constants, state encoding and weighting helper for the
//                PID error front-end (err_compute) and its sat_signed stage.
//                  NUM_CH     - sensor channels per measurement round
//                  RES_W      - A2D result width (unsigned)
//                  ACC_W      - signed accumulator width
//                  ERR_W      - saturated error width (signed)
//                  W_TBL      - per-channel signed weights (even=left, odd=right)
//                  ACC_SHIFT  - arithmetic right shift applied before saturation
//                  ERR_MAX/MIN- clamp limits of the ERR_W signed error
//  Revision    : 1.0 - initial release
// ============================================================================
package err_pkg;

   localparam int NUM_CH    = 8;
   localparam int CH_W      = 3;
   localparam int RES_W     = 12;
   localparam int ACC_W     = 17;
   localparam int ERR_W     = 10;
   localparam int ACC_SHIFT = 3;
   localparam int ERR_MAX   = 511;
   localparam int ERR_MIN   = -512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STRT = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } err_state_t;

   localparam logic signed [4:0] W_TBL [NUM_CH] = '{
      5'sd1, -5'sd1, 5'sd2, -5'sd2, 5'sd4, -5'sd4, 5'sd8, -5'sd8
   };

   // Every weight is +/- a power of two, so the product is a left shift of the
   // zero-extended result followed by an optional negation; no multiplier.
   function automatic logic signed [ACC_W-1:0] weighted_res(
      input logic [CH_W-1:0]  idx,
      input logic [RES_W-1:0] res
   );
      logic signed [4:0]  w;
      logic [4:0]         mag;
      logic [ACC_W-1:0]   ext;
      logic [ACC_W-1:0]   mag_prod;
      logic signed [ACC_W-1:0] p;
      w   = W_TBL[idx];
      mag = w[4] ? 5'(-w) : 5'(w);
      ext = {{(ACC_W-RES_W){1'b0}}, res};
      case (mag)
         5'd1:    mag_prod = ext;
         5'd2:    mag_prod = ext << 1;
         5'd4:    mag_prod = ext << 2;
         5'd8:    mag_prod = ext << 3;
         default: mag_prod = '0;
      endcase
      p = signed'(mag_prod);
      return w[4] ? -p : p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_signed.sv
`default_nettype none
// ============================================================================
//  Module      : sat_signed
//  Description : Combinational signed clamp from IN_W bits to OUT_W bits.
//                Values above the OUT_W positive maximum return the maximum,
//                values below the OUT_W negative minimum return the minimum,
//                everything else passes through as its low OUT_W bits.
//  Ports       : din  in  IN_W   signed value to clamp
//                dout out OUT_W  clamped signed value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_signed #(
   parameter int IN_W  = 17,
   parameter int OUT_W = 10
) (
   input  logic signed [IN_W-1:0]  din,
   output logic        [OUT_W-1:0] dout
);

   generate
      if (IN_W > OUT_W) begin : g_clamp
         localparam logic [OUT_W-1:0] c_max = {1'b0, {(OUT_W-1){1'b1}}};
         localparam logic [OUT_W-1:0] c_min = {1'b1, {(OUT_W-1){1'b0}}};
         logic w_ovf;
         // In range exactly when every bit from the OUT_W sign bit upward
         // agrees with the input sign bit.
         assign w_ovf = !((&din[IN_W-1:OUT_W-1]) || !(|din[IN_W-1:OUT_W-1]));
         assign dout  = !w_ovf       ? din[OUT_W-1:0] :
                        din[IN_W-1]  ? c_min          : c_max;
      end else begin : g_pass
         assign dout = OUT_W'(din);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/err_compute.sv
`default_nettype none
// ============================================================================
//  Module      : err_compute
//  Description : PID error front-end. On go, converts each of the NUM_CH IR
//                sensor channels in turn, accumulates the signed weighted sum,
//                then scales (>>>3) and clamps it to an ERR_W signed error.
//                Optional macro ERR_FILT_EN: the published error becomes a
//                two-tap IIR, err_sat <= (err_sat + new) >>> 1.
//  Ports       : clk       in   1      system clock
//                rst       in   1      asynchronous active-high reset
//                go        in   1      start one measurement round
//                strt_cnv  out  1      one-cycle A2D convert request
//                chnnl     out  3      channel being converted
//                cnv_cmplt in   1      A2D done strobe, res valid with it
//                res       in   RES_W  A2D result (unsigned)
//                err_sat   out  ERR_W  saturated signed error (registered)
//                err_vld   out  1      one-cycle strobe, err_sat is new
//                busy      out  1      round in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module err_compute
   import err_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   output logic             strt_cnv,
   output logic [CH_W-1:0]  chnnl,
   input  logic             cnv_cmplt,
   input  logic [RES_W-1:0] res,
   output logic [ERR_W-1:0] err_sat,
   output logic             err_vld,
   output logic             busy
);

   err_state_t              r_state;
   err_state_t              w_state_nxt;
   logic [CH_W-1:0]         r_idx;
   logic signed [ACC_W-1:0] r_acc;
   logic [ERR_W-1:0]        r_err_sat;

   logic                    w_last;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic signed [ACC_W-1:0] w_scaled;
   logic [ERR_W-1:0]        w_sat;
   logic [ERR_W-1:0]        w_err_nxt;

   assign w_last    = (r_idx == CH_W'(NUM_CH-1));
   assign w_acc_nxt = r_acc + weighted_res(r_idx, res);
   assign w_scaled  = w_acc_nxt >>> ACC_SHIFT;

   // The error is formed from the accumulator value that includes the final
   // channel, so it is already registered when err_vld rises in DONE.
   sat_signed #(
      .IN_W  (ACC_W),
      .OUT_W (ERR_W)
   ) u_sat (
      .din  (w_scaled),
      .dout (w_sat)
   );

`ifdef ERR_FILT_EN
   logic signed [ERR_W:0] w_filt_sum;
   assign w_filt_sum = {r_err_sat[ERR_W-1], r_err_sat} + {w_sat[ERR_W-1], w_sat};
   assign w_err_nxt  = w_filt_sum[ERR_W:1];
`else
   assign w_err_nxt  = w_sat;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      strt_cnv    = 1'b0;
      err_vld     = 1'b0;
      case (r_state)
         IDLE: begin
            if (go) w_state_nxt = STRT;
         end
         STRT: begin
            strt_cnv    = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (cnv_cmplt) w_state_nxt = w_last ? DONE : STRT;
         end
         DONE: begin
            err_vld     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx     <= '0;
         r_acc     <= '0;
         r_err_sat <= '0;
      end else begin
         if (r_state == IDLE && go) begin
            r_idx <= '0;
            r_acc <= '0;
         end else if (r_state == WAIT && cnv_cmplt) begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
               r_err_sat <= w_err_nxt;
            end else begin
               r_idx <= r_idx + 3'd1;
            end
         end
      end
   end

   assign chnnl   = r_idx;
   assign err_sat = r_err_sat;
   assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_err_compute.sv
`default_nettype none
// ============================================================================
//  Module      : tb_err_compute
//  Description : Directed self-checking bench for err_compute. A small A2D
//                responder answers each strt_cnv after a programmable delay
//                and logs channel order, strobe counts and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_err_compute;

   logic        clk;
   logic        rst;
   logic        go;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic [9:0]  err_sat;
   logic        err_vld;
   logic        busy;

   err_compute dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .err_sat   (err_sat),
      .err_vld   (err_vld),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [11:0] tb_vals [8];
   int          tb_delay = 2;
   int          cyc = 0;
   int          pend = 0;
   logic [2:0]  pend_ch = '0;
   int          strt_cnt = 0;
   int          vld_cnt = 0;
   int          cmplt_cyc = -1;
   int          vld_cyc = -1;
   logic [23:0] ch_pack = '0;
   logic [9:0]  vld_err = '0;
   logic [9:0]  model_err = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      strt_cnt  = 0;
      vld_cnt   = 0;
      cmplt_cyc = -1;
      vld_cyc   = -1;
      ch_pack   = '0;
   endtask

   task automatic set_vals(input int ch, input logic [11:0] v);
      for (int i = 0; i < 8; i++) tb_vals[i] = 12'h000;
      tb_vals[ch] = v;
   endtask

   // Expected published error given the hand-computed unfiltered value.
   task automatic model_update(input logic [9:0] raw);
`ifdef ERR_FILT_EN
      logic [10:0] sum;
      sum       = {model_err[9], model_err} + {raw[9], raw};
      model_err = sum[10:1];
`else
      model_err = raw;
`endif
   endtask

   // A2D responder / strobe monitor, sampled 1 time unit after each edge.
   initial begin
      cnv_cmplt = 1'b0;
      res       = 12'h000;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            pend      = 0;
            cnv_cmplt = 1'b0;
         end else begin
            if (cnv_cmplt) begin
               cnv_cmplt = 1'b0;
               res       = 12'hABC;
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  cnv_cmplt = 1'b1;
                  res       = tb_vals[pend_ch];
                  if (pend_ch == 3'd7) cmplt_cyc = cyc;
               end
            end
            if (strt_cnv) begin
               if (strt_cnt < 8) ch_pack = ch_pack | (24'(chnnl) << (3 * strt_cnt));
               strt_cnt++;
               pend    = tb_delay;
               pend_ch = chnnl;
            end
            if (err_vld) begin
               vld_cnt++;
               vld_cyc = cyc;
               vld_err = err_sat;
            end
         end
      end
   end

   task automatic wait_vld(input string tag);
      int n;
      n = 0;
      while (vld_cnt == 0 && n < 2000) begin
         @(posedge clk); #2;
         n++;
      end
      check({tag, "_timeout"}, 32'(vld_cnt > 0), 32'd1);
   endtask

   task automatic do_round(input string tag, input logic [9:0] raw, input int delay, input bit rego);
      int n;
      clear_logs();
      tb_delay = delay;
      go = 1'b1;
      @(posedge clk); #2;
      go = 1'b0;
      check({tag, "_strt_lat"}, 32'(strt_cnv), 32'd1);
      n = 0;
      while (vld_cnt == 0 && n < 2000) begin
         if (rego && n == 30) begin
            check({tag, "_busy_mid"}, 32'(busy), 32'd1);
            go = 1'b1;
         end else begin
            go = 1'b0;
         end
         @(posedge clk); #2;
         n++;
      end
      go = 1'b0;
      check({tag, "_timeout"}, 32'(vld_cnt > 0), 32'd1);
      model_update(raw);
      check({tag, "_err"}, 32'(vld_err), 32'(model_err));
      check({tag, "_vld_lat"}, 32'(vld_cyc - cmplt_cyc), 32'd1);
      repeat (3) begin @(posedge clk); #2; end
      check({tag, "_vld_cnt"}, 32'(vld_cnt), 32'd1);
      check({tag, "_strt_cnt"}, 32'(strt_cnt), 32'd8);
      check({tag, "_ch_order"}, 32'(ch_pack), 32'h00FAC688);
      check({tag, "_hold"}, 32'(err_sat), 32'(model_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      go  = 1'b0;
      for (int i = 0; i < 8; i++) tb_vals[i] = 12'h000;
      repeat (3) begin @(posedge clk); #2; end
      check("rst_err_sat", 32'(err_sat), 32'd0);
      check("rst_err_vld", 32'(err_vld), 32'd0);
      check("rst_strt",    32'(strt_cnv), 32'd0);
      check("rst_chnnl",   32'(chnnl), 32'd0);
      check("rst_busy",    32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // All channels mid-scale: weights cancel to zero.
      for (int i = 0; i < 8; i++) tb_vals[i] = 12'h800;
      do_round("mid", 10'h000, 2, 1'b0);

      set_vals(6, 12'hFFF);                 // +32760 >>> 3 = 4095 -> clamp
      do_round("pos_sat", 10'h1FF, 2, 1'b0);
      set_vals(7, 12'hFFF);                 // -32760 >>> 3 = -4095 -> clamp
      do_round("neg_sat", 10'h200, 2, 1'b0);
      set_vals(0, 12'h100);                 // 256 >>> 3 = 32
      do_round("ch0", 10'h020, 2, 1'b0);
      set_vals(1, 12'h100);                 // -256 >>> 3 = -32
      do_round("ch1", 10'h3E0, 2, 1'b0);

      // Slow A2D with a second go while busy.
      set_vals(0, 12'h100);
      do_round("rego", 10'h020, 20, 1'b1);

      // Reset while waiting on channel 4.
      clear_logs();
      set_vals(2, 12'hFFF);
      tb_delay = 20;
      go = 1'b1;
      @(posedge clk); #2;
      go = 1'b0;
      n = 0;
      while (strt_cnt < 5 && n < 500) begin @(posedge clk); #2; n++; end
      check("rst_reach_ch4", 32'(strt_cnt), 32'd5);
      @(posedge clk); #2;
      check("rst_pre_chnnl", 32'(chnnl), 32'd4);
      check("rst_pre_busy",  32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #2;
      check("arst_err_sat", 32'(err_sat), 32'd0);
      check("arst_err_vld", 32'(err_vld), 32'd0);
      check("arst_strt",    32'(strt_cnv), 32'd0);
      check("arst_chnnl",   32'(chnnl), 32'd0);
      check("arst_busy",    32'(busy), 32'd0);
      rst = 1'b0;
      model_err = 10'h000;
      repeat (40) begin @(posedge clk); #2; end
      check("arst_no_vld", 32'(vld_cnt), 32'd0);

      set_vals(0, 12'h100);
      do_round("post_rst_a", 10'h020, 2, 1'b0);
      set_vals(1, 12'h100);
      do_round("post_rst_b", 10'h3E0, 2, 1'b0);

      // go during DONE is dropped; go in the following IDLE cycle starts.
      clear_logs();
      set_vals(6, 12'hFFF);
      tb_delay = 3;
      go = 1'b1;
      @(posedge clk); #2;
      go = 1'b0;
      wait_vld("b2b_a");
      model_update(10'h1FF);
      check("b2b_a_err", 32'(vld_err), 32'(model_err));
      clear_logs();
      go = 1'b1;
      @(posedge clk); #2;
      check("done_go_ign_strt", 32'(strt_cnv), 32'd0);
      check("done_go_ign_busy", 32'(busy), 32'd0);
      @(posedge clk); #2;
      go = 1'b0;
      check("idle_go_strt", 32'(strt_cnv), 32'd1);
      wait_vld("b2b_b");
      model_update(10'h1FF);
      check("b2b_b_err", 32'(vld_err), 32'(model_err));
      check("b2b_b_strt_cnt", 32'(strt_cnt), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/err_compute.md
Name: err_compute

Overview:
- Front-end of the PID error path; sits directly upstream of the derivative and integral stages.
- Sequences one A2D conversion per IR sensor channel (8 channels) and accumulates a signed, weighted sum of the readings.
- Scales and saturates the sum to a 10-bit signed error, presented on err_sat with a one-cycle err_vld strobe.
- err_sat/err_vld drive the derivative-term and integral-term blocks directly.

Parameters:
- NUM_CH, 8, number of sensor channels per round (weight table sized for 8).
- RES_W, 12, A2D result width (unsigned).
- ACC_W, 17, signed accumulator width.
- ERR_W, 10, saturated error output width (signed).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start one measurement round (single-cycle pulse).
- strt_cnv  out  1  one-cycle request to the A2D to convert channel chnnl.
- chnnl  out  3  channel index for the current conversion.
- cnv_cmplt  in  1  A2D done strobe; res is valid while it is high.
- res  in  RES_W  A2D conversion result, unsigned.
- err_sat  out  ERR_W  saturated signed error, registered.
- err_vld  out  1  one-cycle strobe; err_sat is new in this cycle.
- busy  out  1  high from the cycle after go until the cycle err_vld is asserted.

Behaviour:
- Reset values: err_sat=0, err_vld=0, strt_cnv=0, chnnl=0, busy=0, acc=0, state=IDLE.
- States and transitions:
  - IDLE: go=1 → clear acc, set idx=0, go to STRT.
  - STRT: strt_cnv=1 for exactly this cycle, chnnl=idx, go to WAIT.
  - WAIT: on cnv_cmplt=1, acc <= acc + W[idx]*res; then go to DONE if idx==NUM_CH-1, else idx++ and go to STRT. Waits indefinitely otherwise.
  - DONE: err_sat <= sat(acc >>> 3); err_vld=1 for this cycle only; go to IDLE.
- Weights W[0..7] = +1, -1, +2, -2, +4, -4, +8, -8. Even channels are the left sensors, odd channels the right.
- Arithmetic:
  - res is zero-extended before multiplication.
  - Products are formed by shifts.
  - Accumulation is signed over ACC_W; the worst case is ±61425, so it cannot overflow.
- Saturation: value > 511 → 0x1FF; value < -512 → 0x200; otherwise take the low 10 bits.
- Latency:
  - go at cycle 0 → strt_cnv at cycle 1.
  - cnv_cmplt for the last channel at cycle N → err_vld at cycle N+1.
- chnnl holds its value from STRT through WAIT.
- go while busy=1 is ignored. It is not queued.
- cnv_cmplt outside WAIT is ignored.
- err_sat holds its value between rounds.
- Reset mid-round returns all outputs to reset values immediately. No err_vld is issued for the aborted round.
- go asserted in the DONE cycle is ignored. go in the first IDLE cycle afterwards starts a new round, so back-to-back rounds are spaced by one cycle.

Optional Feature:
- Macro: ERR_FILT_EN.
- Defined: the DONE update becomes err_sat <= (err_sat + sat(acc>>>3)) >>> 1. This is an 11-bit signed intermediate, a two-tap IIR, and no second saturation is required. The filter state is err_sat itself, cleared by rst.
- Undefined: err_sat is the unfiltered saturated value. There is no extra logic.

Decomposition:
- Package err_pkg holds:
  - the widths (RES_W, ACC_W, ERR_W);
  - the state enum (IDLE, STRT, WAIT, DONE);
  - the weight table as a constant array of signed 5-bit values;
  - the shift amount (3);
  - the saturation limits (511, -512).
- One natural combinational sub-module, sat_signed: parameterised input and output widths, clamps a signed value. It is reused by later PID stages.

Test Plan:
- All eight res = 0x800, cnv_cmplt 2 cycles after each strt_cnv → err_sat=0x000, err_vld pulses once, exactly 8 strt_cnv pulses with chnnl 0..7 in order.
- ch6 = 0xFFF, others 0 → acc=32760, err_sat=0x1FF (positive saturation). ch7 = 0xFFF, others 0 → err_sat=0x200.
- ch0 = 0x100, others 0 → err_sat=32 (0x020). ch1 = 0x100, others 0 → err_sat=-32 (0x3E0).
- cnv_cmplt delayed 20 cycles per channel, go re-pulsed mid-round → FSM holds in WAIT, second go has no effect, single err_vld.
- rst pulsed while in WAIT on channel 4 → all outputs 0 next cycle. Subsequent go runs a full clean round with the correct result.
- ERR_FILT_EN defined: round giving 32, then round giving -32 → err_sat 16, then -8.
